// File: rtl/snes_controller_reader_pkg.sv
// Shared types and defaults for the SNES controller port reader.
// State encoding is common to the reader and anything that observes it.
package snes_controller_reader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } snes_state_t;

  localparam int NUM_BITS_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous controller data line.
// Presets to 1 so an idle or floating line reads as "not pressed".
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_controller_reader.sv
// Polls one SNES controller port: latch pulse, serial clock, shift-in,
// and a stable active-high button word updated once per poll frame.
module snes_controller_reader
  import snes_controller_reader_pkg::*;
#(
  parameter int HALF_PERIOD = 300,
  parameter int POLL_PERIOD = 833333,
  parameter int NUM_BITS    = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snes_data,
  output logic                snes_latch,
  output logic                snes_clock,
  output logic [NUM_BITS-1:0] controller_data,
  output logic                data_valid
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int HW = $clog2(2 * HALF_PERIOD);
  localparam int BW = $clog2(NUM_BITS);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_PERIOD - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

  snes_state_t         state;
  logic [PW-1:0]       poll_cnt;
  logic [HW-1:0]       phase_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-1:0] shift_reg;
  logic                data_sync;
  logic                pressed;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (snes_data),
    .q     (data_sync)
  );

  // Controller pulls the line low for a pressed button.
  assign pressed = ~data_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      snes_latch      <= 1'b0;
      snes_clock      <= 1'b1;
      controller_data <= '0;
      data_valid      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          snes_latch <= 1'b0;
          snes_clock <= 1'b1;
          if (poll_cnt == '0) begin
            state      <= LATCH;
            snes_latch <= 1'b1;
            phase_cnt  <= '0;
          end
        end
        LATCH: begin
          if (phase_cnt == LATCH_LAST) begin
            state      <= CLK_LO;
            snes_latch <= 1'b0;
            snes_clock <= 1'b0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= {pressed, shift_reg[NUM_BITS-1:1]};
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        CLK_LO: begin
          if (phase_cnt == HALF_LAST) begin
            state      <= CLK_HI;
            snes_clock <= 1'b1;
            phase_cnt  <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        CLK_HI: begin
          if (phase_cnt == HALF_LAST) begin
            phase_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              state      <= CLK_LO;
              snes_clock <= 1'b0;
              bit_cnt    <= bit_cnt + 1'b1;
              shift_reg  <= {pressed, shift_reg[NUM_BITS-1:1]};
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        DONE: begin
          controller_data <= shift_reg;
          data_valid      <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
